fp_flopoco_wb_convert: RTL and testbench

- Downstream stage of the single-precision FP divide/square-root unit.
- Consumes its writeback beats (done/id/34-bit FloPoCo result) and converts each result to IEEE-754 binary32.
- Buffers converted results in a small in-order FIFO so the div/sqrt unit can retire into it without waiting on the register-file writeback arbiter.
- Presents the converted results to the arbiter with the standard done/ack handshake.

---
 rtl/fp_flopoco_wb_convert.sv | 104 ++++++++++
 tb/tb_fp_flopoco_wb_convert.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_flopoco_wb_convert.sv
// Writeback stage behind the FP div/sqrt unit: converts FloPoCo results to binary32 and
// queues them in an in-order FIFO in front of the register-file writeback arbiter.
module fp_flopoco_wb_convert #(
   parameter int          DEPTH         = 2,
   parameter int          ID_WIDTH      = 3,
   parameter logic [31:0] CANONICAL_NAN = 32'h7FC00000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_done,
   input  logic [ID_WIDTH-1:0] in_id,
   input  logic [33:0]         in_rd,
   output logic                in_ack,
   output logic                out_done,
   output logic [ID_WIDTH-1:0] out_id,
   output logic [31:0]         out_rd,
   output logic                out_is_nan,
   output logic                out_is_inf,
   input  logic                out_ack
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Handshake: a beat moves on a side only in a cycle where its done and ack are both high.
   // in_ack looks only at registered occupancy, so out_ack never reaches it combinationally.

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [ID_WIDTH-1:0] id_mem_q  [DEPTH];
   logic [31:0]         rd_mem_q  [DEPTH];
   logic                nan_mem_q [DEPTH];
   logic                inf_mem_q [DEPTH];

   logic        push, pop, empty;
   logic [31:0] conv_rd;
   logic        conv_nan, conv_inf;

   // NaN payload and sign are dropped so every NaN leaves the unit in one canonical form.
   always_comb begin
      conv_rd  = 32'h0;
      conv_nan = 1'b0;
      conv_inf = 1'b0;
      case (in_rd[33:32])
         2'b00: conv_rd = {in_rd[31], 31'h0};
         2'b01: conv_rd = in_rd[31:0];
         2'b10: begin
            conv_rd  = {in_rd[31], 8'hFF, 23'h0};
            conv_inf = 1'b1;
         end
         default: begin
            conv_rd  = CANONICAL_NAN;
            conv_nan = 1'b1;
         end
      endcase
   end

   assign empty  = (count_q == '0);
   assign in_ack = (count_q < FULL_CNT);
   assign push   = in_done && in_ack;
   assign pop    = !empty && out_ack;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         id_mem_q[wr_ptr_q]  <= in_id;
         rd_mem_q[wr_ptr_q]  <= conv_rd;
         nan_mem_q[wr_ptr_q] <= conv_nan;
         inf_mem_q[wr_ptr_q] <= conv_inf;
      end
   end

   assign out_done   = !empty;
   assign out_id     = empty ? '0    : id_mem_q[rd_ptr_q];
   assign out_rd     = empty ? 32'h0 : rd_mem_q[rd_ptr_q];
   assign out_is_nan = empty ? 1'b0  : nan_mem_q[rd_ptr_q];
   assign out_is_inf = empty ? 1'b0  : inf_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fp_flopoco_wb_convert.sv
// Bench for fp_flopoco_wb_convert: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fp_flopoco_wb_convert;

   localparam int          DEPTH = 2;
   localparam int          IDW   = 3;
   localparam int          W     = IDW + 32 + 2;
   localparam logic [31:0] CNAN  = 32'h7FC00000;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_done;
   logic [IDW-1:0]  in_id;
   logic [33:0]     in_rd;
   logic            in_ack;
   logic            out_done;
   logic [IDW-1:0]  out_id;
   logic [31:0]     out_rd;
   logic            out_is_nan;
   logic            out_is_inf;
   logic            out_ack;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   fp_flopoco_wb_convert #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .CANONICAL_NAN(CNAN)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_done    (in_done),
      .in_id      (in_id),
      .in_rd      (in_rd),
      .in_ack     (in_ack),
      .out_done   (out_done),
      .out_id     (out_id),
      .out_rd     (out_rd),
      .out_is_nan (out_is_nan),
      .out_is_inf (out_is_inf),
      .out_ack    (out_ack)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_conv(input logic [IDW-1:0] id, input logic [33:0] rd);
      logic [31:0] v;
      logic        nan, inf;
      nan = 1'b0;
      inf = 1'b0;
      if (rd[33:32] == 2'd0)      v = rd[31] ? 32'h80000000 : 32'h0;
      else if (rd[33:32] == 2'd1) v = rd[31:0];
      else if (rd[33:32] == 2'd2) begin
         v   = rd[31] ? 32'hFF800000 : 32'h7F800000;
         inf = 1'b1;
      end else begin
         v   = CNAN;
         nan = 1'b1;
      end
      return {id, v, nan, inf};
   endfunction

   // Model advances on the same edge as the DUT; inputs change only #1 after the edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
      end else begin
         automatic bit do_pop  = (exp_q.size() > 0) && out_ack;
         automatic bit do_push = in_done && (exp_q.size() < DEPTH);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(model_conv(in_id, in_rd));
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      automatic logic [W-1:0] h = '0;
      if (exp_q.size() > 0) h = exp_q[0];
      check("in_ack",     32'(in_ack),     32'(exp_q.size() < DEPTH));
      check("out_done",   32'(out_done),   32'(exp_q.size() > 0));
      check("out_id",     32'(out_id),     32'(h[W-1 -: IDW]));
      check("out_rd",     out_rd,          h[33:2]);
      check("out_is_nan", 32'(out_is_nan), 32'(h[1]));
      check("out_is_inf", 32'(out_is_inf), 32'(h[0]));
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the beat until it is accepted; returns #1 after the accepting edge with in_done still high.
   task automatic push_beat(input logic [IDW-1:0] id, input logic [33:0] rd);
      logic acc;
      int   n;
      n       = 0;
      in_done = 1'b1;
      in_id   = id;
      in_rd   = rd;
      do begin
         acc = in_ack;
         step();
         n++;
      end while (!acc && n < 20);
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_timeout: beat id %0d not accepted within %0d cycles", id, n);
      end
   endtask

   localparam logic [33:0] ONE_P0 = {2'b01, 1'b0, 8'h7F, 23'h0};
   localparam logic [33:0] NEG_Z  = {2'b00, 1'b1, 8'h55, 23'h1234};
   localparam logic [33:0] POS_I  = {2'b10, 1'b0, 8'h00, 23'h0};
   localparam logic [33:0] NAN_V  = {2'b11, 1'b1, 8'h12, 23'h1};

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b0;
      in_done = 1'b0;
      in_id   = '0;
      in_rd   = '0;
      out_ack = 1'b0;
      step();
      check("rst_out_done", 32'(out_done), 32'd0);
      check("rst_in_ack",   32'(in_ack),   32'd1);
      rst = 1'b1;
      step();

      // Normal value, one-cycle latency
      push_beat(3'd5, ONE_P0);
      in_done = 1'b0;
      check("norm_done", 32'(out_done), 32'd1);
      check("norm_rd",   out_rd,        32'h3F800000);
      check("norm_id",   32'(out_id),   32'd5);
      check("norm_nan",  32'(out_is_nan), 32'd0);
      check("norm_inf",  32'(out_is_inf), 32'd0);
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      check("norm_drained", 32'(out_done), 32'd0);

      // Specials streamed back to back
      out_ack = 1'b1;
      push_beat(3'd1, NEG_Z);
      check("negz_rd",  out_rd, 32'h80000000);
      check("negz_inf", 32'(out_is_inf), 32'd0);
      push_beat(3'd2, POS_I);
      check("inf_rd",   out_rd, 32'h7F800000);
      check("inf_inf",  32'(out_is_inf), 32'd1);
      check("inf_nan",  32'(out_is_nan), 32'd0);
      push_beat(3'd3, NAN_V);
      check("nan_rd",   out_rd, 32'h7FC00000);
      check("nan_nan",  32'(out_is_nan), 32'd1);
      check("nan_inf",  32'(out_is_inf), 32'd0);
      in_done = 1'b0;
      step();
      out_ack = 1'b0;

      // Backpressure: fill, hold id 3, then drain
      in_done = 1'b1;
      in_rd   = ONE_P0;
      in_id   = 3'd1;
      step();
      in_id   = 3'd2;
      step();
      check("bp_full_ack", 32'(in_ack), 32'd0);
      in_id   = 3'd3;
      step();
      check("bp_still_full", 32'(in_ack), 32'd0);
      check("bp_head1",      32'(out_id), 32'd1);
      out_ack = 1'b1;
      step();
      check("bp_head2",    32'(out_id), 32'd2);
      check("bp_ack_back", 32'(in_ack), 32'd1);
      step();
      check("bp_head3", 32'(out_id), 32'd3);
      in_done = 1'b0;
      step();
      check("bp_empty", 32'(out_done), 32'd0);
      out_ack = 1'b0;

      // Simultaneous push and pop at count=1
      push_beat(3'd4, ONE_P0);
      in_id   = 3'd6;
      out_ack = 1'b1;
      step();
      check("pp_head", 32'(out_id), 32'd6);
      check("pp_done", 32'(out_done), 32'd1);
      in_done = 1'b0;
      step();
      out_ack = 1'b0;

      // Streaming through pointer wrap
      out_ack = 1'b1;
      in_done = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_id = IDW'(i % 8);
         in_rd = {2'b01, 32'($urandom)};
         step();
         check("stream_id",  32'(out_id), 32'(i % 8));
         check("stream_ack", 32'(in_ack), 32'd1);
      end
      in_done = 1'b0;
      step();
      out_ack = 1'b0;

      // Asynchronous reset with two entries queued and a beat in flight
      in_done = 1'b1;
      in_rd   = ONE_P0;
      in_id   = 3'd1;
      step();
      in_id   = 3'd2;
      step();
      in_id   = 3'd7;
      #3;
      rst = 1'b0;
      #1;
      check("arst_done", 32'(out_done), 32'd0);
      check("arst_ack",  32'(in_ack),   32'd1);
      in_done = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      in_done = 1'b1;
      in_id   = 3'd6;
      in_rd   = NEG_Z;
      check("post_rst_empty", 32'(out_done), 32'd0);
      step();
      check("post_rst_done", 32'(out_done), 32'd1);
      check("post_rst_id",   32'(out_id),   32'd6);
      check("post_rst_rd",   out_rd,        32'h80000000);
      in_done = 1'b0;
      out_ack = 1'b1;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_done = ($urandom_range(0, 3) != 0);
         in_id   = IDW'($urandom_range(0, 7));
         in_rd   = {2'($urandom_range(0, 3)), 32'($urandom)};
         out_ack = ($urandom_range(0, 9) < 6);
         step();
      end
      in_done = 1'b0;
      out_ack = 1'b1;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
